// File: rtl/upower_pkg.sv
// Shared uPower datapath types and widths.
package upower_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DONE  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/upower_fetch_unit.sv
// Instruction fetch: owns the PC, indexes the combinational instruction memory and
// presents fetched instructions to decode through a valid/ready output register.
module upower_fetch_unit
  import upower_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_WORDS = 3
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               done,
  output logic               fault,
  output logic [31:0]        retired_count
);

  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic               out_valid_n;
  logic [INSTR_W-1:0] out_instr_n;
  logic [ADDR_W-1:0]  out_pc_n;
  logic [31:0]        retired_count_n;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               reg_free;

  function automatic logic word_in_range(input logic [ADDR_W-1:0] addr);
    return {2'b00, addr[ADDR_W-1:2]} < ADDR_W'(IMEM_WORDS);
  endfunction

  assign fetch_addr = redirect_valid ? redirect_target : pc;
  assign imem_addr  = {2'b00, fetch_addr[ADDR_W-1:2]};
  assign reg_free   = !out_valid || out_ready;

  // Next-state and next-output logic; redirects take priority over sequential fetch.
  always_comb begin
    state_n         = state;
    pc_n            = pc;
    out_valid_n     = out_valid;
    out_instr_n     = out_instr;
    out_pc_n        = out_pc;
    retired_count_n = retired_count;

    if (out_valid && out_ready) begin
      retired_count_n = retired_count + 32'd1;
    end

    case (state)
      RUN, DONE: begin
        if (redirect_valid) begin
          if (redirect_target[1:0] != 2'b00) begin
            out_valid_n = 1'b0;
            state_n     = FAULT;
          end else if (word_in_range(redirect_target)) begin
            out_valid_n = 1'b1;
            out_instr_n = imem_data;
            out_pc_n    = redirect_target;
            pc_n        = redirect_target + ADDR_W'(4);
            state_n     = RUN;
          end else begin
            out_valid_n = 1'b0;
            pc_n        = redirect_target;
            state_n     = DONE;
          end
        end else if (state == RUN && reg_free) begin
          if (word_in_range(pc)) begin
            out_valid_n = 1'b1;
            out_instr_n = imem_data;
            out_pc_n    = pc;
            pc_n        = pc + ADDR_W'(4);
          end else begin
            out_valid_n = 1'b0;
            state_n     = DONE;
          end
        end
      end
      default: begin
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc            <= RESET_PC;
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      done          <= 1'b0;
      fault         <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      out_valid     <= out_valid_n;
      out_instr     <= out_instr_n;
      out_pc        <= out_pc_n;
      done          <= (state_n == DONE);
      fault         <= (state_n == FAULT);
      retired_count <= retired_count_n;
    end
  end

endmodule

// File: tb/tb_upower_fetch_unit.sv
// Randomized and directed bench for upower_fetch_unit against a behavioural fetch model.
module tb_upower_fetch_unit;

  localparam int unsigned NW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        done;
  logic        fault;
  logic [31:0] retired_count;

  logic [31:0] mem [NW];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: PC, output register contents, mode (0 fetching, 1 ended, 2 faulted), handshake count.
  logic [31:0] m_pc, m_instr, m_opc, m_cnt;
  logic        m_valid;
  int          m_mode;

  upower_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .done(done), .fault(fault), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'(NW)) ? mem[imem_addr[1:0]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return ((a >> 2) < 32'(NW)) ? mem[a[3:2]] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] tgt,
                            input logic rdy);
    logic accepted;
    if (rst) begin
      m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_cnt = 0; m_mode = 0;
      return;
    end
    accepted = m_valid && rdy;
    if (m_mode != 2 && rv) begin
      if (tgt % 4 != 0) begin
        m_valid = 0; m_mode = 2;
      end else if ((tgt / 4) < NW) begin
        m_valid = 1; m_instr = model_word(tgt); m_opc = tgt; m_pc = tgt + 4; m_mode = 0;
      end else begin
        m_valid = 0; m_pc = tgt; m_mode = 1;
      end
    end else if (m_mode == 0 && (!m_valid || rdy)) begin
      if ((m_pc / 4) < NW) begin
        m_valid = 1; m_instr = model_word(m_pc); m_opc = m_pc; m_pc = m_pc + 4;
      end else begin
        m_valid = 0; m_mode = 1;
      end
    end
    if (accepted) m_cnt = m_cnt + 1;
  endtask

  // Drive one cycle of inputs, compare every output with the model, then clock.
  task automatic cycle(input logic rst, input logic rv, input logic [31:0] tgt, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_target = tgt; out_ready = rdy;
    @(negedge clk);
    check("imem_addr", imem_addr, (rv ? tgt : m_pc) >> 2);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_instr", out_instr, m_instr);
      check("out_pc", out_pc, m_opc);
    end
    check("done", 32'(done), 32'(m_mode == 1));
    check("fault", 32'(fault), 32'(m_mode == 2));
    check("retired_count", retired_count, m_cnt);
    model_step(rst, rv, tgt, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
  endtask

  logic [31:0] saved_cnt;

  initial begin
    mem[0] = 32'h7C22_1A14;
    mem[1] = 32'h3860_0005;
    mem[2] = 32'h4800_0008;
    m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_cnt = 0; m_mode = 0;

    // Straight-line run to the end of memory.
    do_reset();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_pc", out_pc, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      check("seq_valid", 32'(out_valid), 1);
      check("seq_pc", out_pc, 32'(4 * i));
    end
    cycle(0, 0, 0, 1);
    check("end_valid", 32'(out_valid), 0);
    check("end_done", 32'(done), 1);
    check("end_retired", retired_count, 3);

    // Backpressure holds the output register and the PC.
    do_reset();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      check("bp_instr", out_instr, 32'h7C22_1A14);
      check("bp_pc", out_pc, 0);
      check("bp_imem_addr", imem_addr, 1);
    end
    cycle(0, 0, 0, 1);
    check("bp_resume_pc", out_pc, 4);

    // Redirect flushes a stalled entry without counting it.
    cycle(0, 0, 0, 1);
    check("pre_redir_pc", out_pc, 8);
    saved_cnt = retired_count;
    cycle(0, 1, 0, 0);
    check("flush_pc", out_pc, 0);
    check("flush_instr", out_instr, 32'h7C22_1A14);
    check("flush_retired", retired_count, saved_cnt);

    // Redirect out of DONE restarts the sequence.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    check("done_again", 32'(done), 1);
    cycle(0, 1, 0, 1);
    check("restart_done", 32'(done), 0);
    check("restart_pc0", out_pc, 0);
    cycle(0, 0, 0, 1);
    check("restart_pc4", out_pc, 4);
    cycle(0, 0, 0, 1);
    check("restart_pc8", out_pc, 8);

    // Misaligned redirect is sticky until reset.
    cycle(0, 1, 32'h6, 1);
    check("fault_set", 32'(fault), 1);
    check("fault_valid", 32'(out_valid), 0);
    cycle(0, 1, 0, 1);
    check("fault_sticky", 32'(fault), 1);
    check("fault_no_valid", 32'(out_valid), 0);
    do_reset();
    cycle(0, 0, 0, 1);
    check("post_fault_pc", out_pc, 0);
    check("post_fault_valid", 32'(out_valid), 1);

    // Reset mid-stream.
    cycle(1, 0, 0, 1);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_instr", out_instr, 0);
    check("midrst_pc", out_pc, 0);
    check("midrst_retired", retired_count, 0);
    check("midrst_done", 32'(done), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_rv, r_rdy;
      logic [31:0] r_tgt;
      int          pick;
      r_rst = ($urandom_range(0, 79) == 0);
      r_rv  = ($urandom_range(0, 5) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      pick  = int'($urandom_range(0, 19));
      if (pick == 0)      r_tgt = $urandom_range(1, 3) + 32'(4 * $urandom_range(0, 3));
      else if (pick == 1) r_tgt = $urandom & 32'hFFFF_FFFC;
      else                r_tgt = 32'(4 * $urandom_range(0, 4));
      cycle(r_rst, r_rv, r_tgt, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
